spi_register_responder: RTL
===========================

Name: spi_register_responder

Overview:
- SPI mode-0 slave on the host MCU link (FPGA_SPI_SCLK/MOSI/CS0_N/MISO). It runs entirely in the 25 MHz system clock domain by oversampling the SPI pins.
- It decodes host frames into single-cycle register read/write strobes on a 7-bit address / 8-bit data register bus, and returns read data on MISO.
- It is the FPGA-side responder; the host MCU is the SPI initiator.
- The top level tri-states MISO using spi_miso_oe, so bypass and responder modes can share the pin.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on spi_sclk, spi_mosi and spi_cs_n before edge detection (minimum 2).
- IDLE_BYTE, 8'hFF: byte shifted out on MISO during the command byte.

Ports:
- clock  in  1  system clock (CLK25MHz).
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  host SPI clock, asynchronous to clock.
- spi_mosi  in  1  host data in.
- spi_cs_n  in  1  host chip select, active low.
- spi_miso  out  1  data out; valid only while spi_miso_oe=1.
- spi_miso_oe  out  1  MISO output enable; equals the synchronized ~spi_cs_n.
- reg_address  out  7  register address for the current strobe.
- reg_write  out  1  one-cycle write strobe.
- reg_writedata  out  8  write data; valid while reg_write=1.
- reg_read  out  1  one-cycle read strobe.
- reg_readdata  in  8  read data; sampled exactly 1 cycle after reg_read.
- frame_active  out  1  high while a frame is being decoded.
- partial_byte_error  out  1  sticky flag for a frame that ended mid-byte; cleared only by reset.

Behaviour:
- Reset values:
  - spi_miso=1, spi_miso_oe=0.
  - reg_write=0, reg_read=0, reg_address=0, reg_writedata=0.
  - frame_active=0, partial_byte_error=0.
  - Bit counter = 0. Synchronizers are filled with idle levels (sclk=0, cs_n=1).
- Input path: every pin passes through SYNC_STAGES flip-flops. Edges are detected against one further registered copy.
- Timing limits:
  - Edge-to-action latency is SYNC_STAGES+1 cycles.
  - Supported SCLK is at most 2 MHz, with each half-period at least 6 clocks.
  - CS setup to the first SCLK edge is at least 4 clocks.
- Frame format:
  - Byte 0 is the command {rw, addr[6:0]}; rw=1 means read.
  - Every following byte is data, MSB first.
  - Base address = addr. Data byte n (n≥1) targets addr+n-1, wrapping 7'h7F → 7'h00.
- State machine:
  - WAIT_IDLE: entered from reset. Stays until synchronized cs_n=1, then goes to IDLE. A frame already in progress at reset is therefore ignored in full.
  - IDLE → COMMAND on synchronized cs_n falling edge. This loads the tx shift register with IDLE_BYTE and clears the bit counter.
  - COMMAND → WRITE_DATA or READ_DATA on the 8th rising SCLK edge, according to rw.
  - Any state other than WAIT_IDLE → IDLE on synchronized cs_n=1.
- Receive path: MOSI is sampled on each synchronized SCLK rising edge, shifting left. The bit counter wraps 7→0.
- Write path (WRITE_DATA): on each 8th rising edge, reg_write is asserted the following cycle for exactly 1 cycle, with reg_address and reg_writedata valid. No MISO data is defined beyond IDLE_BYTE repeated.
- Read path:
  - On the command byte's 8th rising edge (read), reg_read pulses the next cycle with reg_address=addr. reg_readdata is captured 1 cycle later into a holding register.
  - On every later 8th rising edge in READ_DATA, reg_read pulses for the next address (prefetch). The final prefetch at CS deassertion is harmless, and reg_read is only issued inside the frame.
- Transmit path:
  - spi_miso = tx_shift[7].
  - On each synchronized SCLK falling edge: if the bit counter is 0, load tx_shift from the holding register (READ_DATA) or IDLE_BYTE; otherwise shift left, filling with 1.
- Partial-byte handling: if cs_n deasserts with a nonzero bit counter, the partial byte is discarded, no strobe is issued, and partial_byte_error is set.
- Simultaneity: cs_n deassert in the same cycle as an 8th rising edge counts as deassert first; no strobe is issued.
- Mutual exclusion: reg_write and reg_read are never high in the same cycle.
- frame_active = state is COMMAND, WRITE_DATA or READ_DATA.

Test Plan:
- Reset, then a 1 MHz frame 0x05, 0xA5, 0x3C → reg_write pulses at addr 5 with data 0xA5, then addr 6 with data 0x3C. Each pulse is exactly 1 cycle; no reg_read.
- Read frame 0x82 plus 3 dummy bytes, with the bus model returning 0x10+addr → MISO bytes FF, 12, 13, 14. reg_read is issued at addr 2, 3, 4, 5.
- Write frame 0x7F, 0x11, 0x22 → writes land at addr 7F then 00 (wrap check).
- Read 0x80 then CS raised after 3 bits of byte 2 → partial_byte_error=1 and no extra strobes. The next write frame still works and the flag stays 1.
- Assert reset while CS is low mid-frame → all outputs at reset values, and no strobes until CS rises and a new frame starts.
- CS high with SCLK toggling → no strobes, spi_miso_oe=0, frame_active=0.

Source files
------------

// File: rtl/spi_register_responder_if.sv
// Register bus between the SPI responder (master side) and the register file (slave side).
`timescale 1ns/1ps
interface spi_register_responder_if;
   logic [6:0] reg_address;
   logic       reg_write;
   logic [7:0] reg_writedata;
   logic       reg_read;
   logic [7:0] reg_readdata;

   modport master (
      output reg_address,
      output reg_write,
      output reg_writedata,
      output reg_read,
      input  reg_readdata
   );

   modport slave (
      input  reg_address,
      input  reg_write,
      input  reg_writedata,
      input  reg_read,
      output reg_readdata
   );
endinterface

// File: rtl/spi_register_responder.sv
// SPI mode-0 slave, oversampled in the 25 MHz domain, that turns host frames into
// single-cycle register read/write strobes and returns read data on MISO.
`timescale 1ns/1ps
module spi_register_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            spi_sclk,
   input  logic                            spi_mosi,
   input  logic                            spi_cs_n,
   output logic                            spi_miso,
   output logic                            spi_miso_oe,
   spi_register_responder_if.master        reg_bus,
   output logic                            frame_active,
   output logic                            partial_byte_error
);
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;

   localparam logic [2:0] WAIT_IDLE  = 3'd0;
   localparam logic [2:0] IDLE       = 3'd1;
   localparam logic [2:0] COMMAND    = 3'd2;
   localparam logic [2:0] WRITE_DATA = 3'd3;
   localparam logic [2:0] READ_DATA  = 3'd4;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
   logic                   sclk_d, cs_d;
   logic [SYNC_STAGES:0]   settle;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_fall, settled;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-2:0] rx_shift;
   logic [DATA_W-1:0] rx_byte;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] hold;
   logic [ADDR_W-1:0] next_addr;
   logic              rd_pending;
   logic              in_frame, byte_done;

   logic [ADDR_W-1:0] reg_address_q;
   logic [DATA_W-1:0] reg_writedata_q;
   logic              reg_write_q, reg_read_q;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;
   // The synchronizers hold idle levels right after reset; only trust cs once they have flushed.
   assign settled   = settle[SYNC_STAGES];

   assign in_frame  = (state_q == COMMAND) || (state_q == WRITE_DATA) || (state_q == READ_DATA);
   // cs deassertion wins over a simultaneous 8th rising edge.
   assign byte_done = in_frame && sclk_rise && !cs_s && (bit_cnt == CNT_W'(7));
   assign rx_byte   = {rx_shift, mosi_s};

   assign spi_miso              = tx_shift[DATA_W-1];
   assign reg_bus.reg_address   = reg_address_q;
   assign reg_bus.reg_write     = reg_write_q;
   assign reg_bus.reg_writedata = reg_writedata_q;
   assign reg_bus.reg_read      = reg_read_q;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= WAIT_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_IDLE:  if (settled && cs_s) state_d = IDLE;
         IDLE:       if (cs_fall) state_d = COMMAND;
         COMMAND: begin
            if (cs_s)           state_d = IDLE;
            else if (byte_done) state_d = rx_byte[DATA_W-1] ? READ_DATA : WRITE_DATA;
         end
         WRITE_DATA: if (cs_s) state_d = IDLE;
         READ_DATA:  if (cs_s) state_d = IDLE;
         default:    state_d = WAIT_IDLE;
      endcase
   end

   // Pin synchronizers and edge-detect history.
   always_ff @(posedge clock) begin
      if (reset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         settle    <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
         settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Shift registers, bit counter, register-bus strobes and status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt            <= '0;
         rx_shift           <= '0;
         tx_shift           <= 8'hFF;
         hold               <= '0;
         next_addr          <= '0;
         rd_pending         <= 1'b0;
         reg_address_q      <= '0;
         reg_writedata_q    <= '0;
         reg_write_q        <= 1'b0;
         reg_read_q         <= 1'b0;
         spi_miso_oe        <= 1'b0;
         frame_active       <= 1'b0;
         partial_byte_error <= 1'b0;
      end else begin
         reg_write_q  <= 1'b0;
         reg_read_q   <= 1'b0;
         rd_pending   <= reg_read_q;
         spi_miso_oe  <= ~cs_s;
         frame_active <= (state_d == COMMAND) || (state_d == WRITE_DATA) || (state_d == READ_DATA);
         if (rd_pending) hold <= reg_bus.reg_readdata;

         if (state_q == IDLE && cs_fall) begin
            tx_shift <= IDLE_BYTE;
            bit_cnt  <= '0;
         end else if (in_frame) begin
            if (cs_s) begin
               if (bit_cnt != '0) partial_byte_error <= 1'b1;
               bit_cnt <= '0;
            end else begin
               if (sclk_rise) begin
                  rx_shift <= rx_byte[DATA_W-2:0];
                  bit_cnt  <= CNT_W'(bit_cnt + CNT_W'(1));
               end
               if (sclk_fall) begin
                  if (bit_cnt == '0) tx_shift <= (state_q == READ_DATA) ? hold : IDLE_BYTE;
                  else               tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
               end
               if (byte_done) begin
                  case (state_q)
                     COMMAND: begin
                        if (rx_byte[DATA_W-1]) begin
                           reg_read_q    <= 1'b1;
                           reg_address_q <= rx_byte[ADDR_W-1:0];
                           next_addr     <= ADDR_W'(rx_byte[ADDR_W-1:0] + ADDR_W'(1));
                        end else begin
                           next_addr     <= rx_byte[ADDR_W-1:0];
                        end
                     end
                     WRITE_DATA: begin
                        reg_write_q     <= 1'b1;
                        reg_address_q   <= next_addr;
                        reg_writedata_q <= rx_byte;
                        next_addr       <= ADDR_W'(next_addr + ADDR_W'(1));
                     end
                     READ_DATA: begin
                        reg_read_q    <= 1'b1;
                        reg_address_q <= next_addr;
                        next_addr     <= ADDR_W'(next_addr + ADDR_W'(1));
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end
endmodule
